// File: rtl/console_uart_tx.sv
// console_uart_tx: buffers console bytes in a FIFO and serializes them as UART frames (LSB first, 1 stop bit).
// Optional build macro CONSOLE_UART_PARITY_EN inserts an even-parity bit between the data and stop bits.
module console_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [7:0]       in_bits,
  output logic             uart_txd,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0]    BIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] ONE      = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

`ifdef CONSOLE_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_next;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count, count_next;
  logic [CW-1:0]        baud;
  logic [2:0]           idx;
  logic [7:0]           sh;
  logic                 reset_n_q;
  logic                 txd_next;
  logic                 push, pop, bit_end;
`ifdef CONSOLE_UART_PARITY_EN
  logic                 par;
`endif

  // in_rdy looks only at the pre-edge count, so a pop on a full FIFO never admits a same-edge push
  assign in_rdy     = reset_n_q && (count != FULL);
  assign push       = in_val && in_rdy;
  assign bit_end    = (baud == BIT_LAST);
  assign fifo_count = count;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    txd_next   = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        txd_next = sh[0];
        if (bit_end && (idx == 3'd7)) begin
`ifdef CONSOLE_UART_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef CONSOLE_UART_PARITY_EN
      PARITY: begin
        txd_next = par;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        // a queued byte starts its frame straight after the stop bit, with no idle bit
        if (bit_end) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + ONE;
    else if (pop && !push) count_next = count - ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      baud      <= '0;
      idx       <= '0;
      sh        <= '0;
      uart_txd  <= 1'b1;
      busy      <= 1'b0;
      reset_n_q <= 1'b0;
`ifdef CONSOLE_UART_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      reset_n_q <= 1'b1;
      state     <= state_next;
      count     <= count_next;
      uart_txd  <= txd_next;
      busy      <= (state_next != IDLE) || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if ((state == IDLE) || bit_end) baud <= '0;
      else                            baud <= baud + CW'(1);
      if (pop) begin
        sh     <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
        idx    <= '0;
`ifdef CONSOLE_UART_PARITY_EN
        par    <= ^mem[rd_ptr];
`endif
      end else if ((state == DATA) && bit_end) begin
        sh  <= {1'b0, sh[7:1]};
        idx <= idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= in_bits;
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: table of single frames, a 12-byte burst with stall, and a mid-frame reset.
// A negedge monitor decodes uart_txd and checks each frame against a queue of accepted bytes.
`timescale 1ns/1ps
module tb_console_uart_tx;
  localparam int unsigned CD    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef CONSOLE_UART_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FL = NB * CD;

  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] frame;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_val;
  logic          in_rdy;
  logic [7:0]    in_bits;
  logic          uart_txd;
  logic          busy;
  logic [AW:0]   fifo_count;

  always #5 clk = ~clk;

  console_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy), .in_bits(in_bits),
    .uart_txd(uart_txd), .busy(busy), .fifo_count(fifo_count)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int unsigned   cyc = 0;
  logic [7:0]    exp_q[$];
  int unsigned   start_q[$];
  logic [NB-1:0] last_frame;
  int unsigned   frames_seen = 0;
  logic          mon_active = 1'b0;
  int unsigned   mon_off = 0;
  logic [NB-1:0] mon_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n === 1'b1 && in_val === 1'b1 && in_rdy === 1'b1) exp_q.push_back(in_bits);
  end

  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (reset_n !== 1'b1) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active) begin
        if (uart_txd === 1'b0) begin
          mon_active = 1'b1;
          mon_off    = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_off++;
      end
      if (mon_active && (mon_off % CD) == CD / 2) begin
        mon_bits[mon_off / CD] = uart_txd;
        if (mon_off / CD == NB - 1) begin
          mon_active = 1'b0;
          last_frame = mon_bits;
          frames_seen++;
          check("start_bit", 32'(mon_bits[0]), 32'd0);
          check("stop_bit", 32'(mon_bits[NB-1]), 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", mon_bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", 32'(mon_bits[8:1]), 32'(exp_b));
`ifdef CONSOLE_UART_PARITY_EN
            check("parity_bit", 32'(mon_bits[9]), 32'(^exp_b));
`endif
          end
        end
      end
    end
  end

  // Presents a byte until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int unsigned acc);
    in_val  = 1'b1;
    in_bits = b;
    acc     = 0;
    for (int unsigned k = 0; k < 400; k++) begin
      if (in_rdy === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance within 400 cycles", b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    int unsigned acc, base, tmp, fs0;
    logic        low_seen;

`ifdef CONSOLE_UART_PARITY_EN
    tbl[0] = '{8'h55, 11'b1_0_01010101_0};
    tbl[1] = '{8'h07, 11'b1_1_00000111_0};
    tbl[2] = '{8'h03, 11'b1_0_00000011_0};
    tbl[3] = '{8'h00, 11'b1_0_00000000_0};
    tbl[4] = '{8'hFF, 11'b1_0_11111111_0};
    tbl[5] = '{8'h80, 11'b1_1_10000000_0};
`else
    tbl[0] = '{8'h55, 10'b1_01010101_0};
    tbl[1] = '{8'h07, 10'b1_00000111_0};
    tbl[2] = '{8'h03, 10'b1_00000011_0};
    tbl[3] = '{8'h00, 10'b1_00000000_0};
    tbl[4] = '{8'hFF, 10'b1_11111111_0};
    tbl[5] = '{8'h80, 10'b1_10000000_0};
`endif

    reset_n = 1'b0;
    in_val  = 1'b0;
    in_bits = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(uart_txd), 32'd1);
    check("reset_in_rdy", 32'(in_rdy), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    #1 check("rdy_at_release", 32'(in_rdy), 32'd0);
    @(negedge clk);
    check("rdy_after_release", 32'(in_rdy), 32'd1);

    for (int i = 0; i < 6; i++) begin
      fs0 = frames_seen;
      start_q.delete();
      send(tbl[i].data, acc);
      in_val = 1'b0;
      while (cyc < acc + FL) @(negedge clk);
      check("busy_last_cycle", 32'(busy), 32'd1);
      @(negedge clk);
      check("busy_after_frame", 32'(busy), 32'd0);
      check("txd_after_frame", 32'(uart_txd), 32'd1);
      check("frame_count", fs0 == frames_seen ? 32'd0 : 32'(frames_seen - fs0), 32'd1);
      check("frame_bits", 32'(last_frame), 32'(tbl[i].frame));
      check("start_count", 32'(start_q.size()), 32'd1);
      if (start_q.size() >= 1) check("start_latency", start_q[0] - acc, 32'd2);
    end

    fs0 = frames_seen;
    start_q.delete();
    base = 0;
    for (int i = 0; i < 12; i++) begin
      send(8'(i), acc);
      if (i == 0) base = acc;
      if (i == 8) begin
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_in_rdy", 32'(in_rdy), 32'd0);
      end
      if (i == 9) check("rdy_return", acc - base, FL + 2);
    end
    in_val = 1'b0;
    for (int unsigned k = 0; k < 12 * FL + 200 && frames_seen - fs0 < 12; k++) @(negedge clk);
    check("burst_frames", frames_seen - fs0, 32'd12);
    check("burst_starts", 32'(start_q.size()), 32'd12);
    if (start_q.size() == 12) begin
      check("burst_first_start", start_q[0] - base, 32'd2);
      for (int i = 1; i < 12; i++) check("back_to_back", start_q[i] - start_q[i-1], FL);
    end
    for (int unsigned k = 0; k < 200 && busy === 1'b1; k++) @(negedge clk);
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    fs0 = frames_seen;
    send(8'hA5, acc);
    send(8'h3C, tmp);
    send(8'h96, tmp);
    in_val = 1'b0;
    while (cyc < acc + 19) @(negedge clk);
    check("queued_before_reset", 32'(fifo_count), 32'd2);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_txd", 32'(uart_txd), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_in_rdy", 32'(in_rdy), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rdy_at_release2", 32'(in_rdy), 32'd0);
    @(negedge clk);
    check("rdy_after_release2", 32'(in_rdy), 32'd1);
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    check("no_residual_txd", 32'(low_seen), 32'd0);
    check("no_residual_frame", frames_seen - fs0, 32'd0);
    check("no_residual_busy", 32'(busy), 32'd0);
    check("no_residual_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
